// File: rtl/median_core_5x5_pkg.sv
// -----------------------------------------------------------------------------
// median_pkg
// Shared types, constants and helpers for the 5x5 median filter core.
//   pix_t       : one pixel sample
//   win_t       : the 25 samples of a 5x5 window, flattened row-major (r*5+c)
//   N_SAMPLES   : samples per window
//   LAT         : input-to-DPo latency in clocks (window + stage0 + 8 + out)
//   RANK_DEFAULT: rank from the top of the sorted window that is the median
//   popcount25  : population count of a 25-bit mask (0..25)
// -----------------------------------------------------------------------------
package median_pkg;

    localparam int PIX_W        = 8;
    localparam int N_SAMPLES    = 25;
    localparam int LAT          = 11;
    localparam int RANK_DEFAULT = 13;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [N_SAMPLES-1:0] win_t;

    function automatic logic [4:0] popcount25(input logic [N_SAMPLES-1:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_SAMPLES; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/median_core_5x5_if.sv
// -----------------------------------------------------------------------------
// median_core_5x5_if
// Pixel stream bundle between the 5-line buffer stage, the median core and the
// display/stream sink.
//   DPi_sync   : {vsync, hsync, den}, aligned to line_in_*
//   line_in_0-4: one column sample per row, row 0 is the oldest line
//   DPo        : {vsync, hsync, den, median}
// Modports: master = stream source (bench / line buffer), slave = median core.
// -----------------------------------------------------------------------------
interface median_core_5x5_if #(
    parameter int DATA_WIDTH = 8
);
    logic [2:0]            DPi_sync;
    logic [DATA_WIDTH-1:0] line_in_0;
    logic [DATA_WIDTH-1:0] line_in_1;
    logic [DATA_WIDTH-1:0] line_in_2;
    logic [DATA_WIDTH-1:0] line_in_3;
    logic [DATA_WIDTH-1:0] line_in_4;
    logic [DATA_WIDTH+2:0] DPo;

    modport master (
        output DPi_sync, line_in_0, line_in_1, line_in_2, line_in_3, line_in_4,
        input  DPo
    );

    modport slave (
        input  DPi_sync, line_in_0, line_in_1, line_in_2, line_in_3, line_in_4,
        output DPo
    );
endinterface

// File: rtl/median_core_5x5_radix_stage.sv
// -----------------------------------------------------------------------------
// median_radix_stage
// One MSB-first radix-select step on bit BIT of the 25 window samples.
//   clk, rst_n : clock, async active-low reset
//   smp_i/o    : the 25 samples (carried forward for the lower-bit stages)
//   msk_i/o    : candidates still in the running for the selected rank
//   rk_i/o     : rank still to find among the candidates (1-based, from top)
//   res_i/o    : result bits decided so far
// If at least rk candidates have a 1 at BIT, the answer has a 1 there and only
// those candidates survive; otherwise the answer has a 0, the 1-candidates
// are dropped and the rank shifts down by their count.
// -----------------------------------------------------------------------------
module median_radix_stage
    import median_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BIT        = DATA_WIDTH - 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_SAMPLES-1:0][DATA_WIDTH-1:0] smp_i,
    input  logic [N_SAMPLES-1:0]                 msk_i,
    input  logic [4:0]                           rk_i,
    input  logic [DATA_WIDTH-1:0]                res_i,
    output logic [N_SAMPLES-1:0][DATA_WIDTH-1:0] smp_o,
    output logic [N_SAMPLES-1:0]                 msk_o,
    output logic [4:0]                           rk_o,
    output logic [DATA_WIDTH-1:0]                res_o
);
    localparam logic [DATA_WIDTH-1:0] BIT_MASK = DATA_WIDTH'(1) << BIT;

    logic [N_SAMPLES-1:0]                 bits;
    logic [4:0]                           cnt;
    logic                                 take;
    logic [N_SAMPLES-1:0]                 msk_d, msk_q;
    logic [4:0]                           rk_d, rk_q;
    logic [DATA_WIDTH-1:0]                res_d, res_q;
    logic [N_SAMPLES-1:0][DATA_WIDTH-1:0] smp_q;

    always_comb begin
        bits = '0;
        for (int j = 0; j < N_SAMPLES; j++) begin
            bits[j] = smp_i[j][BIT];
        end
        cnt   = popcount25(msk_i & bits);
        take  = (cnt >= rk_i);
        msk_d = take ? (msk_i & bits) : (msk_i & ~bits);
        // cnt < rk_i on this branch, so the subtraction cannot wrap
        rk_d  = take ? rk_i : (rk_i - cnt);
        res_d = take ? (res_i | BIT_MASK) : res_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q <= '0;
            msk_q <= '0;
            rk_q  <= '0;
            res_q <= '0;
        end else begin
            smp_q <= smp_i;
            msk_q <= msk_d;
            rk_q  <= rk_d;
            res_q <= res_d;
        end
    end

    // Either the all-zero reset bubble, or a live rank within the candidates.
    always @(posedge clk) begin
        if (rst_n) begin
            assert ((rk_i == 5'd0 && msk_i == '0) ||
                    (rk_i != 5'd0 && rk_i <= popcount25(msk_i)));
        end
    end

    assign smp_o = smp_q;
    assign msk_o = msk_q;
    assign rk_o  = rk_q;
    assign res_o = res_q;
endmodule

// File: rtl/median_core_5x5.sv
// -----------------------------------------------------------------------------
// median_core_5x5
// 5x5 median filter: builds a sliding window from five aligned line taps and
// selects the RANK-th largest of the 25 samples with a bit-serial radix-select
// pipeline; sync bits are delayed to match so DPo drives the sink directly.
//   ref_clk : pixel clock
//   rst_n   : async active-low reset
//   dp      : slave side of median_core_5x5_if (DPi_sync, line_in_0..4, DPo)
// Latency DPi -> DPo is DATA_WIDTH+3 clocks (11 at 8 bits). The median emitted
// with the i-th den pixel of a line is centred on input column i-2.
// Build option MEDIAN_EDGE_REPLICATE_EN: a den rising edge loads every window
// column with the incoming column instead of shifting, so a line starts with a
// replicated edge rather than the previous line's tail.
// -----------------------------------------------------------------------------
module median_core_5x5
    import median_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WIN        = 5,
    parameter int RANK       = RANK_DEFAULT
) (
    input  logic              ref_clk,
    input  logic              rst_n,
    median_core_5x5_if.slave  dp
);
    localparam int SYNC_DEPTH = DATA_WIDTH + 3;

    if (WIN != 5) begin : g_bad_win
        $error("median_core_5x5: WIN must be 5");
    end
    if (RANK < 1 || RANK > N_SAMPLES) begin : g_bad_rank
        $error("median_core_5x5: RANK out of range 1..25");
    end

    logic                                 den;
    logic [4:0][DATA_WIDTH-1:0]           col_in;
    logic [4:0][4:0][DATA_WIDTH-1:0]      win_d, win_q;   // [row][col], col 4 newest

    assign den    = dp.DPi_sync[0];
    assign col_in = {dp.line_in_4, dp.line_in_3, dp.line_in_2, dp.line_in_1, dp.line_in_0};

`ifdef MEDIAN_EDGE_REPLICATE_EN
    logic den_prev_q;

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) den_prev_q <= 1'b0;
        else        den_prev_q <= den;
    end

    always_comb begin
        win_d = win_q;
        if (den && !den_prev_q) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    win_d[r][c] = col_in[r];
        end else if (den) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) win_d[r][c] = win_q[r][c+1];
                win_d[r][4] = col_in[r];
            end
        end
    end
`else
    always_comb begin
        win_d = win_q;
        if (den) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) win_d[r][c] = win_q[r][c+1];
                win_d[r][4] = col_in[r];
            end
        end
    end
`endif

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) win_q <= '0;
        else        win_q <= win_d;
    end

    // Stage 0 samples the window every cycle so the pipeline keeps flowing
    // even while den is low (output stays deterministic).
    logic [N_SAMPLES-1:0][DATA_WIDTH-1:0] s0_smp_q;
    logic [N_SAMPLES-1:0]                 s0_msk_q;
    logic [4:0]                           s0_rk_q;

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_smp_q <= '0;
            s0_msk_q <= '0;
            s0_rk_q  <= '0;
        end else begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    s0_smp_q[r*5+c] <= win_q[r][c];
            s0_msk_q <= '1;
            s0_rk_q  <= 5'(RANK);
        end
    end

    logic [N_SAMPLES-1:0][DATA_WIDTH-1:0] smp [DATA_WIDTH+1];
    logic [N_SAMPLES-1:0]                 msk [DATA_WIDTH+1];
    logic [4:0]                           rk  [DATA_WIDTH+1];
    logic [DATA_WIDTH-1:0]                res [DATA_WIDTH+1];

    assign smp[0] = s0_smp_q;
    assign msk[0] = s0_msk_q;
    assign rk[0]  = s0_rk_q;
    assign res[0] = '0;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_stage
        median_radix_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .BIT        (DATA_WIDTH - 1 - i)
        ) u_stage (
            .clk   (ref_clk),
            .rst_n (rst_n),
            .smp_i (smp[i]),
            .msk_i (msk[i]),
            .rk_i  (rk[i]),
            .res_i (res[i]),
            .smp_o (smp[i+1]),
            .msk_o (msk[i+1]),
            .rk_o  (rk[i+1]),
            .res_o (res[i+1])
        );
    end

    // The last stage's carried samples/mask/rank have no consumer.
    logic unused_tail;
    assign unused_tail = ^{smp[DATA_WIDTH], msk[DATA_WIDTH], rk[DATA_WIDTH]};

    // Sync delay: SYNC_DEPTH-1 taps here plus the output register.
    logic [SYNC_DEPTH-2:0][2:0] sync_q;
    logic [DATA_WIDTH+2:0]      dpo_q;

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dpo_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-3:0], dp.DPi_sync};
            dpo_q  <= {sync_q[SYNC_DEPTH-2], res[DATA_WIDTH]};
        end
    end

    assign dp.DPo = dpo_q;
endmodule

// File: tb/tb_median_core_5x5.sv
module tb_median_core_5x5;
    import median_pkg::*;

    localparam int DW   = 8;
    localparam int LATC = 11;
`ifdef MEDIAN_EDGE_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    logic ref_clk = 1'b0;
    logic rst_n   = 1'b1;

    median_core_5x5_if #(.DATA_WIDTH(DW)) dif ();

    median_core_5x5 #(.DATA_WIDTH(DW), .WIN(5), .RANK(13)) dut (
        .ref_clk (ref_clk),
        .rst_n   (rst_n),
        .dp      (dif)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct {
        logic [10:0] dpo;
        int          cst;   // independent constant for the median, -1 = none
    } exp_t;

    exp_t       sbq[$];
    int         n_tests   = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         first_in  = -1;
    int         first_out = -1;
    logic [7:0] mw [5][5];
    logic       mden_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference median: full sort, then pick the 13th largest.
    function automatic logic [7:0] model_med();
        logic [7:0] a[25];
        logic [7:0] t;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                a[r*5+c] = mw[r][c];
        for (int i = 0; i < 25; i++)
            for (int j = 0; j < 24 - i; j++)
                if (a[j] < a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[12];
    endfunction

    task automatic step(input logic [2:0] sync, input logic [7:0] c0, input logic [7:0] c1,
                        input logic [7:0] c2, input logic [7:0] c3, input logic [7:0] c4,
                        input int cst);
        logic [7:0] col[5];
        exp_t       e;
        int         in_c;
        col = '{c0, c1, c2, c3, c4};
        dif.DPi_sync  = sync;
        dif.line_in_0 = c0;
        dif.line_in_1 = c1;
        dif.line_in_2 = c2;
        dif.line_in_3 = c3;
        dif.line_in_4 = c4;
        in_c = cyc;
        @(posedge ref_clk);
        #1;
        cyc++;
        if (sync[0]) begin
            if (REPL && !mden_prev) begin
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++) mw[r][c] = col[r];
            end else begin
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 4; c++) mw[r][c] = mw[r][c+1];
                    mw[r][4] = col[r];
                end
            end
        end
        mden_prev = sync[0];
        if (sync[0] && first_in < 0) first_in = in_c;
        e.dpo = {sync, model_med()};
        e.cst = cst;
        sbq.push_back(e);
        if (sbq.size() == LATC) begin
            e = sbq.pop_front();
            chk("sb_dpo", 32'(dif.DPo), 32'(e.dpo));
            if (e.cst >= 0) chk("const_med", 32'(dif.DPo[7:0]), e.cst);
        end
        if (dif.DPo[8] && first_out < 0) first_out = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) step(3'b000, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, -1);
    endtask

    task automatic load_win(input logic [7:0] v[25], input int cst);
        for (int c = 0; c < 5; c++)
            step(3'b001, v[c], v[5+c], v[10+c], v[15+c], v[20+c], (c == 4) ? cst : -1);
    endtask

    task automatic shuffle(output int p[25]);
        for (int i = 0; i < 25; i++) p[i] = i;
        for (int i = 24; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_dpo", 32'(dif.DPo), 32'h0);
        repeat (3) begin
            @(posedge ref_clk);
            #1;
            chk("rst_dpo_hold", 32'(dif.DPo), 32'h0);
        end
        rst_n = 1'b1;
        sbq.delete();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) mw[r][c] = 8'h0;
        mden_prev = 1'b0;
    endtask

    initial begin
        int         perm[25];
        logic [7:0] v[25];

        dif.DPi_sync  = 3'b000;
        dif.line_in_0 = '0;
        dif.line_in_1 = '0;
        dif.line_in_2 = '0;
        dif.line_in_3 = '0;
        dif.line_in_4 = '0;
        #2;
        do_reset();

        // 1: flat 0x5A field, den held high; DPo den must trail DPi den by 11
        repeat (5)  step(3'b001, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, -1);
        repeat (15) step(3'b001, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
        idle(12);
        chk("den_latency", 32'(first_out - first_in), 32'd11);

        // 2: permutation of 0..24 -> 12; 100..124 -> 112
        shuffle(perm);
        for (int i = 0; i < 25; i++) v[i] = 8'(perm[i]);
        load_win(v, 12);
        idle(12);
        chk("held_win_med", 32'(dif.DPo[7:0]), 32'd12);
        shuffle(perm);
        for (int i = 0; i < 25; i++) v[i] = 8'(100 + perm[i]);
        load_win(v, 112);
        idle(12);

        // 3: majority boundary
        shuffle(perm);
        for (int i = 0; i < 25; i++) v[i] = (perm[i] < 12) ? 8'h00 : 8'hFF;
        load_win(v, 8'hFF);
        idle(12);
        shuffle(perm);
        for (int i = 0; i < 25; i++) v[i] = (perm[i] < 13) ? 8'h00 : 8'hFF;
        load_win(v, 8'h00);
        idle(12);

        // 4: single impulse in a flat field is removed at every position
        repeat (5) step(3'b001, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, -1);
        for (int j = 0; j < 10; j++)
            step(3'b001, 8'h10, 8'h10, (j == 2) ? 8'hFF : 8'h10, 8'h10, 8'h10, 8'h10);
        idle(12);

        // 5: den toggling with random data and random vsync/hsync
        for (int j = 0; j < 20; j++)
            step({1'($urandom), 1'($urandom), 1'(j % 2 == 0)},
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1);
        idle(12);

        // 6: reset mid-line, then a fresh line starting with a known column
        repeat (6) step(3'b001, 8'($urandom), 8'($urandom), 8'($urandom),
                        8'($urandom), 8'($urandom), -1);
        do_reset();
        step(3'b001, 8'd10, 8'd50, 8'd30, 8'd40, 8'd20, REPL ? 30 : 0);
        repeat (4) step(3'b001, 8'($urandom), 8'($urandom), 8'($urandom),
                        8'($urandom), 8'($urandom), -1);
        idle(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
